sa_tile: RTL

Parametrised output-stationary systolic-array tile: a ROWS x COLS grid of signed multiply-accumulate cells with registered row/column forwarding and a built-in result drain port. It supersedes the fixed 2x2 tile. Tiles abut through their edge outputs to form larger arrays. Each tile drains its own accumulators, one row per beat, over a valid/ready handshake so compute and readout can overlap.

---
 rtl/sa_tile.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sa_tile.sv
// Output-stationary systolic MAC tile with registered edge forwarding and a
// snapshot-based row drain port so readout overlaps continued compute.
module sa_tile #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 16,
    parameter int AW   = 40,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [ROWS*DW-1:0]   a_in,
    input  logic [COLS*DW-1:0]   b_in,
    output logic [ROWS*DW-1:0]   a_out,
    output logic [COLS*DW-1:0]   b_out,
    input  logic                 drain_req,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [COLS*AW-1:0]   res_data,
    output logic [RW-1:0]        res_row,
    output logic                 res_last
);

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic signed [DW-1:0]   a_reg  [ROWS][COLS];
    logic signed [DW-1:0]   b_reg  [ROWS][COLS];
    logic signed [DW-1:0]   a_op   [ROWS][COLS];
    logic signed [DW-1:0]   b_op   [ROWS][COLS];
    logic signed [2*DW-1:0] prod   [ROWS][COLS];
    logic signed [AW-1:0]   acc    [ROWS][COLS];
    logic        [AW-1:0]   shadow [ROWS][COLS];

    state_t          state_reg, state_next;
    logic [RW-1:0]   row_reg, row_next;
    logic            capture;

    // Operand selection: edge cells take tile inputs, inner cells take the neighbour's register.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign a_op[gi][gj] = a_in[gi*DW +: DW];
            end else begin : g_a_inner
                assign a_op[gi][gj] = a_reg[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_op[gi][gj] = b_in[gj*DW +: DW];
            end else begin : g_b_inner
                assign b_op[gi][gj] = b_reg[gi-1][gj];
            end
            assign prod[gi][gj] = a_op[gi][gj] * b_op[gi][gj];
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_out
        assign a_out[gi*DW +: DW] = a_reg[gi][COLS-1];
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_b_out
        assign b_out[gi*DW +: DW] = b_reg[ROWS-1][gi];
    end

    // CLR together with EN restarts accumulation from the current product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                    acc[r][c]   <= '0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (en) begin
                        a_reg[r][c] <= a_op[r][c];
                        b_reg[r][c] <= b_op[r][c];
                        acc[r][c]   <= clr ? AW'(prod[r][c]) : acc[r][c] + AW'(prod[r][c]);
                    end else if (clr) begin
                        acc[r][c] <= '0;
                    end
                end
            end
        end
    end

    // Snapshot takes the accumulator value from before this edge's MAC/clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    shadow[r][c] <= '0;
                end
            end
        end else if (capture) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    shadow[r][c] <= acc[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (drain_req) begin
                    capture    = 1'b1;
                    row_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (res_ready) begin
                    if (row_reg == LAST_ROW) begin
                        row_next   = '0;
                        state_next = IDLE;
                    end else begin
                        row_next = row_reg + RW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg == SEND);
    assign res_valid = busy;
    assign res_row   = row_reg;
    assign res_last  = busy && (row_reg == LAST_ROW);

    for (genvar gj = 0; gj < COLS; gj++) begin : g_res
        assign res_data[gj*AW +: AW] = busy ? shadow[row_reg][gj] : '0;
    end

endmodule
